// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: host-transmit state encoding, default timing constants
// and the odd-parity helper also used by the keyboard receiver.
package ps2_pkg;

   localparam int unsigned DefInhibitCycles = 5000;
   localparam int unsigned DefTimeoutCycles = 1000000;
   localparam int unsigned DefFiltLen       = 4;

   // Data, parity and stop bits shifted out after the start bit.
   localparam int unsigned FrameBits = 10;

   typedef enum logic [2:0] {
      StIdle,
      StInhibit,
      StRts,
      StBits,
      StAck,
      StWaitIdle,
      StDone
   } tx_state_e;

   function automatic logic odd_parity(input logic [7:0] data);
      return ~^data;
   endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Synchronizer plus glitch filter for one PS/2 line; level changes only after
// FILT_LEN equal consecutive samples, and fall pulses on each filtered 1->0.
module ps2_line_filter #(
   parameter int unsigned FILT_LEN = 4
) (
   input  logic m_clock,
   input  logic p_reset,
   input  logic raw,
   output logic level,
   output logic fall
);

   localparam int unsigned CntW = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;

   logic [1:0]      sync_q;
   logic            level_q, level_d;
   logic            fall_q, fall_d;
   logic [CntW-1:0] cnt_q, cnt_d;

   // Idle bus level is high, so reset to 1 to avoid a spurious fall.
   always_ff @(posedge m_clock) begin
      if (p_reset) begin
         sync_q  <= 2'b11;
         level_q <= 1'b1;
         fall_q  <= 1'b0;
         cnt_q   <= '0;
      end else begin
         sync_q  <= {sync_q[0], raw};
         level_q <= level_d;
         fall_q  <= fall_d;
         cnt_q   <= cnt_d;
      end
   end

   // cnt_q tracks how many consecutive samples have disagreed with level_q.
   always_comb begin
      level_d = level_q;
      fall_d  = 1'b0;
      cnt_d   = '0;
      if (sync_q[1] != level_q) begin
         if (cnt_q == CntW'(FILT_LEN - 1)) begin
            level_d = sync_q[1];
            fall_d  = ~sync_q[1];
         end else begin
            cnt_d = cnt_q + CntW'(1);
         end
      end
   end

   assign level = level_q;
   assign fall  = fall_q;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, shift out data,
// parity and stop on device clock falls, then sample the device acknowledge.
module ps2_host_tx
   import ps2_pkg::*;
#(
   parameter int unsigned INHIBIT_CYCLES = DefInhibitCycles,
   parameter int unsigned TIMEOUT_CYCLES = DefTimeoutCycles,
   parameter int unsigned FILT_LEN       = DefFiltLen
) (
   input  logic       m_clock,
   input  logic       p_reset,
   input  logic       tx_valid,
   input  logic [7:0] tx_data,
   output logic       tx_ready,
   output logic       busy,
   input  logic       ps2_clk_in,
   input  logic       ps2_dat_in,
   output logic       ps2_clk_oe,
   output logic       ps2_dat_oe,
   output logic       done,
   output logic       ack_ok,
   output logic       err_timeout
);

   localparam int unsigned InhW = $clog2(INHIBIT_CYCLES + 1);
   localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES + 1);

   tx_state_e               state_q, state_d;
   logic [InhW-1:0]         inh_q, inh_d;
   logic [TmoW-1:0]         tmo_q, tmo_d;
   logic [3:0]              bitcnt_q, bitcnt_d;
   logic [FrameBits-1:0]    sh_q, sh_d;
   logic                    bit_oe_q, bit_oe_d;
   logic                    ack_q, ack_d;
   logic                    err_q, err_d;

   logic clk_level, clk_fall;
   logic dat_level, unused_dat_fall;
   logic timed, tmo_hit;

   ps2_line_filter #(
      .FILT_LEN (FILT_LEN)
   ) u_clk_filt (
      .m_clock (m_clock),
      .p_reset (p_reset),
      .raw     (ps2_clk_in),
      .level   (clk_level),
      .fall    (clk_fall)
   );

   ps2_line_filter #(
      .FILT_LEN (FILT_LEN)
   ) u_dat_filt (
      .m_clock (m_clock),
      .p_reset (p_reset),
      .raw     (ps2_dat_in),
      .level   (dat_level),
      .fall    (unused_dat_fall)
   );

   always_ff @(posedge m_clock) begin
      if (p_reset) begin
         state_q  <= StIdle;
         inh_q    <= '0;
         tmo_q    <= '0;
         bitcnt_q <= '0;
         sh_q     <= '0;
         bit_oe_q <= 1'b0;
         ack_q    <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         inh_q    <= inh_d;
         tmo_q    <= tmo_d;
         bitcnt_q <= bitcnt_d;
         sh_q     <= sh_d;
         bit_oe_q <= bit_oe_d;
         ack_q    <= ack_d;
         err_q    <= err_d;
      end
   end

   // The frame timeout runs from clock release until the lines go idle again.
   assign timed   = state_q inside {StRts, StBits, StAck, StWaitIdle};
   assign tmo_hit = timed && (tmo_q == TmoW'(TIMEOUT_CYCLES - 1));

   always_comb begin
      state_d  = state_q;
      inh_d    = inh_q;
      tmo_d    = tmo_q;
      bitcnt_d = bitcnt_q;
      sh_d     = sh_q;
      bit_oe_d = bit_oe_q;
      ack_d    = ack_q;
      err_d    = err_q;

      if (timed) begin
         tmo_d = tmo_q + TmoW'(1);
      end

      unique case (state_q)
         StIdle: begin
            if (tx_valid) begin
               sh_d     = {1'b1, odd_parity(tx_data), tx_data};
               inh_d    = '0;
               tmo_d    = '0;
               bitcnt_d = '0;
               bit_oe_d = 1'b0;
               ack_d    = 1'b0;
               err_d    = 1'b0;
               state_d  = StInhibit;
            end
         end
         StInhibit: begin
            // Device clock falls here belong to its own aborted frame.
            if (inh_q == InhW'(INHIBIT_CYCLES - 1)) begin
               state_d = StRts;
            end else begin
               inh_d = inh_q + InhW'(1);
            end
         end
         StRts: begin
            if (clk_fall) begin
               bit_oe_d = ~sh_q[0];
               sh_d     = {1'b1, sh_q[FrameBits-1:1]};
               bitcnt_d = 4'd1;
               state_d  = StBits;
            end
         end
         StBits: begin
            if (clk_fall) begin
               bit_oe_d = ~sh_q[0];
               sh_d     = {1'b1, sh_q[FrameBits-1:1]};
               bitcnt_d = bitcnt_q + 4'd1;
               // Fall 10 puts the stop bit (released line) out.
               if (bitcnt_q == 4'(FrameBits - 1)) begin
                  state_d = StAck;
               end
            end
         end
         StAck: begin
            if (clk_fall) begin
               ack_d   = ~dat_level;
               state_d = StWaitIdle;
            end
         end
         StWaitIdle: begin
            if (clk_level && dat_level) begin
               state_d = StDone;
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase

      if (tmo_hit) begin
         state_d = StDone;
         ack_d   = 1'b0;
         err_d   = 1'b1;
      end
   end

   assign tx_ready    = (state_q == StIdle);
   assign busy        = (state_q != StIdle);
   assign ps2_clk_oe  = (state_q == StInhibit);
   assign ps2_dat_oe  = (state_q == StRts) || ((state_q == StBits) && bit_oe_q);
   assign done        = (state_q == StDone);
   assign ack_ok      = done && ack_q;
   assign err_timeout = done && err_q;

endmodule
